// File: rtl/lite16_pkg.sv
// Purpose: shared definitions for the LITE-16 sequencer (state encoding, class priority, ir fields).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lite16_pkg;

  localparam int ADDR_W_DEF = 8;

  // Instruction register field positions
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 12;
  localparam int COND_BIT = 11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_FN  = 3'd0,
    C_RI  = 3'd1,
    C_CMP = 3'd2,
    C_ST  = 3'd3,
    C_LD  = 3'd4,
    C_JMP = 3'd5
  } class_t;

  // Class priority when control_unit raises several flags at once:
  // jmp > ld > st > cmp > ri > fn. Caller checks separately that some flag is set.
  function automatic class_t pick_class(input logic jmp, input logic ld, input logic st,
                                        input logic cmp, input logic ri, input logic fn);
    class_t c;
    c = C_FN;
    if (jmp)      c = C_JMP;
    else if (ld)  c = C_LD;
    else if (st)  c = C_ST;
    else if (cmp) c = C_CMP;
    else if (ri)  c = C_RI;
    else if (fn)  c = C_FN;
    return c;
  endfunction

endpackage

// File: rtl/lite16_pc.sv
// Purpose: program counter; loadable, incrementing, wraps modulo 2^ADDR_W.
// Latency: 1 cycle (registered). Load has priority over increment.
// Backpressure: none. Ports: clk, rst_n, inc, load, load_val -> pc.
module lite16_pc #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/lite16_sequencer.sv
// Purpose: multi-cycle LITE-16 sequencer owning pc, ir and cmp_flag; steps fetch/decode/exec/mem/wb.
// Latency: 3 cycles fn/ri/cmp/jmp, 4 st, 5 ld with zero-wait memory; +1 per memory wait cycle.
// Backpressure: holds mem_req (and address) until mem_ready; all outputs are Moore.
// Ports: run starts from IDLE; mem_* single-port memory handshake; dec_* class flags from
// control_unit (driven by opcode); alu_eq sampled on cmp; alu_en/reg_we strobes; busy/halted status.
module lite16_sequencer
  import lite16_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  input  logic              dec_ri,
  input  logic              dec_cmp,
  input  logic              dec_ld,
  input  logic              dec_st,
  input  logic              dec_jmp,
  input  logic              dec_fn,
  input  logic              alu_eq,
  output logic [3:0]        opcode,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              alu_en,
  output logic              reg_we,
  output logic              busy,
  output logic              halted
);

  state_t state, state_nxt;
  class_t cls, dec_cls;
  logic   cmp_flag;
  logic   pc_inc, pc_load;
  logic   any_dec;

  assign any_dec = dec_jmp | dec_ld | dec_st | dec_cmp | dec_ri | dec_fn;
  assign dec_cls = pick_class(dec_jmp, dec_ld, dec_st, dec_cmp, dec_ri, dec_fn);

  lite16_pc #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (ir[ADDR_W-1:0]),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ir, latched class and compare flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      cls      <= C_FN;
      cmp_flag <= 1'b0;
    end else begin
      if (state == S_FETCH && mem_ready) ir <= mem_rdata;
      if (state == S_DECODE)             cls <= dec_cls;
      if (state == S_EXEC && cls == C_CMP) cmp_flag <= alu_eq;
    end
  end

  // Outputs depend only on state and registers; mem_ready only steers
  // next-state and the pc increment, never an output.
  always_comb begin
    state_nxt = state;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    alu_en    = 1'b0;
    reg_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          pc_inc    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = any_dec ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (cls)
          C_FN, C_RI: begin
            alu_en = 1'b1;
            reg_we = 1'b1;
          end
          C_CMP: alu_en = 1'b1;
          C_LD, C_ST: state_nxt = S_MEM;
          C_JMP: pc_load = !ir[COND_BIT] || cmp_flag;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (cls == C_ST);
        mem_addr = ir[ADDR_W-1:0];
        if (mem_ready) state_nxt = (cls == C_LD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_we    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign opcode = ir[OPC_HI:OPC_LO];
  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_lite16_sequencer.sv
// Purpose: scoreboard bench for lite16_sequencer with a memory responder and a control_unit stand-in.
// Latency: expected events carry absolute cycle stamps from an instruction-level model.
// Backpressure: responder inserts random wait states per request; mem_ready noise while idle.
module tb_lite16_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        dec_ri, dec_cmp, dec_ld, dec_st, dec_jmp, dec_fn, alu_eq;
  logic [3:0]  opcode;
  logic [15:0] ir;
  logic [7:0]  pc, mem_addr;
  logic        mem_req, mem_we, alu_en, reg_we, busy, halted;

  lite16_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dec_ri(dec_ri), .dec_cmp(dec_cmp), .dec_ld(dec_ld), .dec_st(dec_st),
    .dec_jmp(dec_jmp), .dec_fn(dec_fn), .alu_eq(alu_eq),
    .opcode(opcode), .ir(ir), .pc(pc), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .alu_en(alu_en), .reg_we(reg_we), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // control_unit stand-in: flags {jmp,ld,st,cmp,ri,fn}; some opcodes raise several
  function automatic logic [5:0] dec_of(input logic [3:0] op);
    case (op)
      4'h0: dec_of = 6'b000000;
      4'h1: dec_of = 6'b000001;
      4'h2: dec_of = 6'b010000;
      4'h3: dec_of = 6'b001000;
      4'h4: dec_of = 6'b000100;
      4'h5: dec_of = 6'b000010;
      4'h6: dec_of = 6'b100001;
      4'h7: dec_of = 6'b011100;
      4'h8: dec_of = 6'b000111;
      4'h9: dec_of = 6'b000011;
      4'hA: dec_of = 6'b001110;
      4'hF: dec_of = 6'b100000;
      default: dec_of = 6'b000001;
    endcase
  endfunction

  always_comb begin
    {dec_jmp, dec_ld, dec_st, dec_cmp, dec_ri, dec_fn} = dec_of(opcode);
    alu_eq = ir[0];
  end

  // event codes {mem_done, mem_write, alu_en, reg_we}
  localparam logic [3:0] EV_RD = 4'b1000, EV_WR = 4'b1100, EV_ALU = 4'b0010,
                         EV_ALUW = 4'b0011, EV_WB = 4'b0001;

  typedef struct {
    logic [3:0] code;
    logic [7:0] addr;
    int         t;
  } ev_t;

  ev_t         expq[$];
  int          wq[$];
  logic [15:0] mem [256];
  int          total = 0;
  int          bad = 0;
  bit          armed = 0;
  bit          stall = 0;

  function automatic void push(input logic [3:0] code, input logic [7:0] addr, input int t);
    ev_t e;
    e.code = code; e.addr = addr; e.t = t;
    expq.push_back(e);
  endfunction

  // Instruction-level model: walks the program and schedules every visible event.
  task automatic model(input int n, input int t0, input int maxw);
    int t, w;
    logic [7:0]  p;
    logic        flag;
    logic [15:0] word;
    logic [5:0]  f;
    t = t0; p = 8'h00; flag = 1'b0;
    for (int k = 0; k < n; k++) begin
      w = $urandom_range(0, maxw); wq.push_back(w);
      t += w;
      push(EV_RD, p, t);
      word = mem[p];
      p = p + 8'd1;
      t += 2;  // decode, then exec cycle
      f = dec_of(word[15:12]);
      if (f[5]) begin
        if (!word[11] || flag) p = word[7:0];
        t += 1;
      end else if (f[4] || f[3]) begin
        w = $urandom_range(0, maxw); wq.push_back(w);
        t += 1 + w;
        push(f[4] ? EV_RD : EV_WR, word[7:0], t);
        t += 1;
        if (f[4]) begin
          push(EV_WB, 8'h00, t);
          t += 1;
        end
      end else if (f[2]) begin
        push(EV_ALU, 8'h00, t);
        flag = word[0];
        t += 1;
      end else begin
        push(EV_ALUW, 8'h00, t);
        t += 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; stall = 0; armed = 0;
    wq.delete(); expq.delete();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic run_prog(input int n, input int maxw);
    do_reset();
    @(negedge clk); #3;
    model(n, cyc + 1, maxw);
    armed = 1; run = 1'b1;
    for (int i = 0; i < 3000 && expq.size() != 0; i++) begin
      @(negedge clk); #3;
      run = 1'($urandom_range(0, 1));  // ignored outside IDLE
    end
    chk("events_drained", expq.size(), 0);
    armed = 0;
    expq.delete();
  endtask

  initial begin
    fork
      // memory responder
      begin : responder
        bit in_req;
        int wl;
        in_req = 0; wl = 0;
        forever begin
          @(negedge clk); #1;
          if (!rst_n) begin
            in_req = 0; mem_ready = 1'b0;
          end else begin
            if (in_req && mem_ready) in_req = 0;
            if (mem_req && !in_req) begin
              in_req = 1;
              wl = (wq.size() != 0) ? wq.pop_front() : 0;
            end
            if (in_req) begin
              if (stall) mem_ready = 1'b0;
              else begin
                mem_ready = (wl == 0);
                if (wl != 0) wl--;
              end
            end else begin
              mem_ready = 1'($urandom_range(0, 1));
            end
            mem_rdata = mem[mem_addr];
          end
        end
      end
      // monitor
      begin : monitor
        logic [3:0] c;
        logic [7:0] a;
        ev_t e;
        forever begin
          @(negedge clk); #2;
          if (armed && rst_n) begin
            c = {mem_req & mem_ready, mem_req & mem_ready & mem_we, alu_en, reg_we};
            a = (mem_req & mem_ready) ? mem_addr : 8'h00;
            if (c != 4'b0000 || (expq.size() != 0 && expq[0].t == cyc)) begin
              total++;
              if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got code=%b addr=%h t=%0d, expected none", c, a, cyc);
              end else begin
                e = expq.pop_front();
                if (c !== e.code || a !== e.addr || cyc != e.t || busy !== 1'b1 || halted !== 1'b0) begin
                  bad++;
                  $display("FAIL event: got code=%b addr=%h t=%0d busy=%b halted=%b, expected code=%b addr=%h t=%0d busy=1 halted=0",
                           c, a, cyc, busy, halted, e.code, e.addr, e.t);
                end
              end
            end
          end
        end
      end
    join_none

    // reset state
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_reg_we", reg_we, 0);

    // directed program: fn, ld, st, cmp(eq), cond jmp taken, cmp(ne), cond jmp not taken, jmp to FF, wrap
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
    mem[8'h00] = 16'h1000;
    mem[8'h01] = 16'h2042;
    mem[8'h02] = 16'h3055;
    mem[8'h03] = 16'h4001;
    mem[8'h04] = 16'hF830;
    mem[8'h30] = 16'h4000;
    mem[8'h31] = 16'hF840;
    mem[8'h32] = 16'hF0FF;
    mem[8'hFF] = 16'h1000;
    run_prog(12, 0);
    run_prog(12, 2);

    // random programs (opcode 0 excluded so they never halt)
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) begin
        logic [15:0] wd;
        wd = 16'($urandom);
        wd[15:12] = 4'($urandom_range(1, 15));
        mem[i] = wd;
      end
      run_prog(40, 3);
    end

    // illegal opcode halts and stays halted
    do_reset();
    mem[8'h00] = 16'h0000;
    @(negedge clk); #3 run = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_mem_req", mem_req, 0);
    repeat (3) @(negedge clk);
    #3;
    chk("halt_sticky", halted, 1);
    chk("halt_pc", pc, 1);
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_pc", pc, 0);
    chk("halt_rst_busy", busy, 0);
    #2 rst_n = 1'b1;

    // asynchronous reset in the middle of a stalled fetch
    do_reset();
    stall = 1;
    @(negedge clk); #3 run = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    run = 1'b0;
    chk("stall_mem_req", mem_req, 1);
    chk("stall_mem_addr", mem_addr, 0);
    chk("stall_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_busy", busy, 0);
    stall = 0;
    #2 rst_n = 1'b1;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lite16_sequencer.md
# lite16_sequencer

Multi-cycle instruction sequencer for the LITE-16 core. Fetches 16-bit instructions over a single-port memory handshake, presents the opcode to the combinational `control_unit`, and steps the datapath through decode, execute, memory and write-back. It is the only block that owns the program counter, the instruction register and the compare flag, and it drives the strobes that make the register file, ALU and memory act.

## Interface
- `ADDR_W`, default 8: memory address width and PC width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `run` input 1: starts execution from IDLE; ignored in every other state.
- `mem_ready` input 1: memory completes the current request this cycle.
- `mem_rdata` input 16: read data, valid while `mem_ready`=1.
- `dec_ri`, `dec_cmp`, `dec_ld`, `dec_st`, `dec_jmp`, `dec_fn` inputs 1 each: decoded class flags from `control_unit`, driven from `opcode`.
- `alu_eq` input 1: ALU equality result, sampled on cmp execution.
- `opcode` output 4: `ir[15:12]`, routed to `control_unit`.
- `ir` output 16: instruction register.
- `pc` output ADDR_W: program counter.
- `mem_req` output 1: memory request.
- `mem_we` output 1: write request; valid with `mem_req`.
- `mem_addr` output ADDR_W: `pc` in FETCH, `ir[ADDR_W-1:0]` in MEM.
- `alu_en` output 1: one-cycle ALU strobe.
- `reg_we` output 1: one-cycle register-file write strobe.
- `busy` output 1: high in every state except IDLE and HALT.
- `halted` output 1: high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is 3 bits.
- IDLE: go to FETCH when `run`=1.
- FETCH:
  - Hold `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - On `mem_ready`, load `ir`<=`mem_rdata`, increment `pc` modulo 2^ADDR_W, then go to DECODE.
  - With no `mem_ready`, stay in FETCH (wait states are unbounded).
- DECODE: one cycle. Sample the `dec_*` flags and pick a class by fixed priority: jmp > ld > st > cmp > ri > fn. If no flag is set, go to HALT (illegal opcode).
- EXEC, one cycle:
  - fn/ri: `alu_en`=1 and `reg_we`=1, then FETCH.
  - cmp: `alu_en`=1, `cmp_flag`<=`alu_eq`, no `reg_we`, then FETCH.
  - ld/st: `alu_en`=0, go to MEM.
  - jmp: if `ir[11]`=0, or `ir[11]`=1 and `cmp_flag`=1, then `pc`<=`ir[ADDR_W-1:0]`; otherwise `pc` is unchanged. Then FETCH.
- MEM:
  - Hold `mem_req`=1, `mem_we`=(class==st), `mem_addr`=`ir[ADDR_W-1:0]`.
  - On `mem_ready`: ld goes to WB, st goes to FETCH. Otherwise stay.
- WB: `reg_we`=1 for one cycle, then FETCH.
- HALT: sticky; only `rst_n` leaves it.
- `mem_ready` while `mem_req`=0 is ignored.

## Timing
- Reset values: state=IDLE, `pc`=0, `ir`=0, `cmp_flag`=0, and every output strobe 0. Consequently `opcode`=0, `busy`=0, `halted`=0.
- All outputs are Moore, decoded from state and registers. No combinational path from `mem_ready` to any output.
- Minimum cycles per instruction with zero-wait memory (`mem_ready` in the first request cycle):
  - fn/ri/cmp/jmp: 3.
  - st: 4.
  - ld: 5.
  - Each wait cycle adds 1.
- `pc` updates on the FETCH completion edge. A taken jmp overwrites `pc` on the EXEC edge.
- `cmp_flag` updates only in cmp EXEC. A conditional jmp immediately after a cmp sees the new value.
- PC wrap: fetching at `pc`=2^ADDR_W-1 leaves `pc`=0.
- Reset mid-request: `mem_req` falls asynchronously with `rst_n`. The memory must drop the transaction.

## Structure
- Shared package `lite16_pkg` holds:
  - the state encoding constants;
  - the class priority order;
  - the `ir` field positions: opcode [15:12], condition bit 11, address [ADDR_W-1:0];
  - the `ADDR_W` default.
- Natural sub-module: `lite16_pc`. It is a loadable, incrementing, wrapping counter with `inc`, `load` and `load_val` inputs.
- The FSM, `ir` and `cmp_flag` live in the top module.
- `control_unit` is instantiated beside this block, not inside it.

## Test plan
- Reset, then `run`=1 with zero-wait memory and `mem_rdata`=16'h1000, `dec_fn`=1:
  - `mem_req` high with `mem_addr`=0 in the first FETCH;
  - `alu_en` and `reg_we` high exactly on cycle 3;
  - `pc`=1.
- ld with `ir`=16'h2042, `dec_ld`=1, and 2 memory wait cycles in MEM:
  - `mem_addr`=8'h42 and `mem_we`=0;
  - `reg_we` pulses 7 cycles after FETCH start.
- st with `dec_st`=1: `mem_we`=1 in MEM, `reg_we` never asserted, back in FETCH after 4 cycles.
- cmp with `alu_eq`=1, then jmp with `ir`=16'hF830 and `dec_jmp`=1: `pc`=8'h30. Repeat with `alu_eq`=0: `pc` advances sequentially.
- All `dec_*`=0 in DECODE: `halted`=1 and `busy`=0, and the block stays halted despite `run`. `rst_n` pulsed low: state IDLE, `pc`=0.
- `pc` preset to 8'hFF via jmp, then a fetch completes: `pc`=0. Assert `rst_n`=0 mid-FETCH: `mem_req` drops in the same cycle without waiting for a clock edge.
